// File: rtl/rob_param.sv
// -----------------------------------------------------------------------------
// rob_param : parametrised reorder buffer.
//
// Results arrive out of order and the buffer retires them in program order.
// A dispatcher allocates entries at the tail. NUM_WB writeback channels fill
// entries in by tag. The head entry retires once it is ready.
//   reg-write : commit_* pulse to the regfile.
//   jalr      : commit_* pulse, plus a flush that redirects to the target.
//   branch    : bp_* pulse to the predictor; a misprediction also flushes.
//   store     : enters STORE_REQ and drives mem_* until mem_done_in, then pops.
//
// Parameters: DEPTH (entries, power of 2), NUM_WB, XLEN, REG_W; TAG_W = log2(DEPTH).
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (0 = freeze all state)
//   disp_*   : allocation request; disp_rdy_out / disp_tag_out describe the tail
//   lk_*     : two combinational operand lookups {rt,rs}, with writeback forward
//   wb_*     : NUM_WB writeback channels (value or address field)
//   commit_* : registered regfile write pulse
//   bp_*     : registered branch-resolve pulse
//   flush_out, redirect_pc_out : registered pipeline flush pulse and new pc
//   mem_*    : store request, held while in STORE_REQ
//   dbg_state_out, dbg_head_out, dbg_count_out : observation of FSM and pointers
//
// Handshake: mem_en_out is a valid that stays high with stable addr/data/width
// until the cycle in which mem_done_in is high. The entry pops on that edge.
//
// Optional build macro ROB_STATS_EN adds stat_commit_out and stat_flush_out.
// These are 32-bit wrapping counters of retires and flushes.
// -----------------------------------------------------------------------------
module rob_param #(
    parameter int DEPTH  = 16,
    parameter int NUM_WB = 3,
    parameter int XLEN   = 32,
    parameter int REG_W  = 5,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     disp_en_in,
    input  logic [1:0]               disp_kind_in,
    input  logic [REG_W-1:0]         disp_rd_in,
    input  logic [XLEN-1:0]          disp_pc_in,
    input  logic [XLEN-1:0]          disp_target_in,
    input  logic                     disp_taken_in,
    input  logic [2:0]               disp_width_in,
    output logic                     disp_rdy_out,
    output logic [TAG_W-1:0]         disp_tag_out,
    input  logic [2*TAG_W-1:0]       lk_tag_in,
    output logic [1:0]               lk_ready_out,
    output logic [2*XLEN-1:0]        lk_value_out,
    input  logic [NUM_WB-1:0]        wb_valid_in,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag_in,
    input  logic [NUM_WB*XLEN-1:0]   wb_value_in,
    input  logic [NUM_WB*XLEN-1:0]   wb_addr_in,
    input  logic [NUM_WB-1:0]        wb_is_addr_in,
    output logic                     commit_en_out,
    output logic [REG_W-1:0]         commit_rd_out,
    output logic [XLEN-1:0]          commit_value_out,
    output logic [TAG_W-1:0]         commit_tag_out,
    output logic                     bp_en_out,
    output logic                     bp_correct_out,
    output logic [XLEN-1:0]          bp_pc_out,
    output logic                     flush_out,
    output logic [XLEN-1:0]          redirect_pc_out,
    output logic                     mem_en_out,
    output logic [XLEN-1:0]          mem_addr_out,
    output logic [XLEN-1:0]          mem_data_out,
    output logic [2:0]               mem_width_out,
    input  logic                     mem_done_in,
`ifdef ROB_STATS_EN
    output logic [31:0]              stat_commit_out,
    output logic [31:0]              stat_flush_out,
`endif
    output logic                     dbg_state_out,
    output logic [TAG_W-1:0]         dbg_head_out,
    output logic [TAG_W:0]           dbg_count_out
);

    localparam logic [1:0] K_REG  = 2'd0;
    localparam logic [1:0] K_BR   = 2'd1;
    localparam logic [1:0] K_ST   = 2'd2;
    localparam logic [1:0] K_JALR = 2'd3;
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_STORE_REQ = 1'b1} state_t;

    state_t            state;
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_ready;
    logic [DEPTH-1:0]  ent_taken;
    logic [1:0]        ent_kind   [DEPTH];
    logic [REG_W-1:0]  ent_rd     [DEPTH];
    logic [XLEN-1:0]   ent_pc     [DEPTH];
    logic [XLEN-1:0]   ent_target [DEPTH];
    logic [2:0]        ent_width  [DEPTH];
    logic [XLEN-1:0]   ent_value  [DEPTH];
    logic [XLEN-1:0]   ent_addr   [DEPTH];

    // Unpacked views of the flat channel and lookup buses.
    logic [TAG_W-1:0]  wb_tag   [NUM_WB];
    logic [XLEN-1:0]   wb_value [NUM_WB];
    logic [XLEN-1:0]   wb_addr  [NUM_WB];
    logic [TAG_W-1:0]  lk_tag   [2];

    for (genvar c = 0; c < NUM_WB; c++) begin : g_wb
        assign wb_tag[c]   = wb_tag_in[c*TAG_W +: TAG_W];
        assign wb_value[c] = wb_value_in[c*XLEN +: XLEN];
        assign wb_addr[c]  = wb_addr_in[c*XLEN +: XLEN];
    end
    assign lk_tag[0] = lk_tag_in[0 +: TAG_W];
    assign lk_tag[1] = lk_tag_in[TAG_W +: TAG_W];

    // ---------------------------------------------------------------- commit
    logic             head_go;
    logic             outcome;
    logic             pop;
    logic             do_commit;
    logic             do_bp;
    logic             do_flush;
    logic             go_store;
    logic             disp_fire;
    logic [XLEN-1:0]  redirect_nxt;

    // Commit decisions use only registered entry state. A writeback to the
    // head therefore retires on the following edge at the earliest.
    assign head_go = rdy_in && (state == ST_IDLE) && ent_valid[head] && ent_ready[head];
    assign outcome = ent_value[head][0];

    always_comb begin
        pop          = 1'b0;
        do_commit    = 1'b0;
        do_bp        = 1'b0;
        do_flush     = 1'b0;
        go_store     = 1'b0;
        redirect_nxt = '0;
        if (head_go) begin
            case (ent_kind[head])
                K_REG: begin
                    pop       = 1'b1;
                    do_commit = 1'b1;
                end
                K_JALR: begin
                    pop          = 1'b1;
                    do_commit    = 1'b1;
                    do_flush     = 1'b1;
                    redirect_nxt = ent_addr[head];
                end
                K_BR: begin
                    pop   = 1'b1;
                    do_bp = 1'b1;
                    if (outcome != ent_taken[head]) begin
                        do_flush     = 1'b1;
                        redirect_nxt = outcome ? ent_target[head]
                                               : ent_pc[head] + XLEN'(4);
                    end
                end
                default: go_store = 1'b1;
            endcase
        end else if (rdy_in && (state == ST_STORE_REQ) && mem_done_in) begin
            pop = 1'b1;
        end
    end

    // Fullness comes from the registered count. When the buffer is full a
    // dispatch is refused even if the head pops on the same edge. A flush
    // discards any dispatch on its edge.
    assign disp_rdy_out = (count != DEPTH_CNT);
    assign disp_tag_out = tail;
    assign disp_fire    = rdy_in && disp_en_in && disp_rdy_out && !do_flush;

    // ---------------------------------------------------------------- lookup
    always_comb begin
        lk_ready_out = '0;
        lk_value_out = '0;
        for (int l = 0; l < 2; l++) begin
            if (ent_valid[lk_tag[l]]) begin
                if (ent_ready[lk_tag[l]]) begin
                    lk_ready_out[l]            = 1'b1;
                    lk_value_out[l*XLEN +: XLEN] = ent_value[lk_tag[l]];
                end else begin
                    // Forward a writeback that lands at this edge. The loop runs
                    // upward, so the highest channel index wins, as in the write path.
                    for (int c = 0; c < NUM_WB; c++) begin
                        if (rdy_in && wb_valid_in[c] && !wb_is_addr_in[c] &&
                            (wb_tag[c] == lk_tag[l])) begin
                            lk_ready_out[l]            = 1'b1;
                            lk_value_out[l*XLEN +: XLEN] = wb_value[c];
                        end
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- store port
    assign mem_en_out    = (state == ST_STORE_REQ);
    assign mem_addr_out  = mem_en_out ? ent_addr[head]  : '0;
    assign mem_data_out  = mem_en_out ? ent_value[head] : '0;
    assign mem_width_out = mem_en_out ? ent_width[head] : 3'b000;

    assign dbg_state_out = state;
    assign dbg_head_out  = head;
    assign dbg_count_out = count;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= ST_IDLE;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            ent_valid        <= '0;
            ent_ready        <= '0;
            ent_taken        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_kind[i]   <= '0;
                ent_rd[i]     <= '0;
                ent_pc[i]     <= '0;
                ent_target[i] <= '0;
                ent_width[i]  <= '0;
                ent_value[i]  <= '0;
                ent_addr[i]   <= '0;
            end
            commit_en_out    <= 1'b0;
            commit_rd_out    <= '0;
            commit_value_out <= '0;
            commit_tag_out   <= '0;
            bp_en_out        <= 1'b0;
            bp_correct_out   <= 1'b0;
            bp_pc_out        <= '0;
            flush_out        <= 1'b0;
            redirect_pc_out  <= '0;
        end else if (rdy_in) begin
            commit_en_out <= do_commit;
            bp_en_out     <= do_bp;
            flush_out     <= do_flush;
            if (do_commit) begin
                commit_rd_out    <= ent_rd[head];
                commit_value_out <= ent_value[head];
                commit_tag_out   <= head;
            end
            if (do_bp) begin
                bp_correct_out <= (outcome == ent_taken[head]);
                bp_pc_out      <= ent_pc[head];
            end
            if (do_flush) begin
                redirect_pc_out <= redirect_nxt;
            end

            if (go_store) begin
                state <= ST_STORE_REQ;
            end else if ((state == ST_STORE_REQ) && mem_done_in) begin
                state <= ST_IDLE;
            end

            // Later channels override earlier ones when the tags collide.
            // A data writeback also captures the address for jalr, because the
            // redirect target arrives with the link value. A store address
            // arrives separately as an address-only writeback.
            for (int c = 0; c < NUM_WB; c++) begin
                if (wb_valid_in[c] && ent_valid[wb_tag[c]]) begin
                    if (wb_is_addr_in[c]) begin
                        ent_addr[wb_tag[c]] <= wb_addr[c];
                    end else begin
                        ent_value[wb_tag[c]] <= wb_value[c];
                        ent_ready[wb_tag[c]] <= 1'b1;
                        if (ent_kind[wb_tag[c]] == K_JALR) begin
                            ent_addr[wb_tag[c]] <= wb_addr[c];
                        end
                    end
                end
            end

            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end

            if (disp_fire) begin
                ent_valid[tail]  <= 1'b1;
                ent_ready[tail]  <= 1'b0;
                ent_kind[tail]   <= disp_kind_in;
                ent_rd[tail]     <= disp_rd_in;
                ent_pc[tail]     <= disp_pc_in;
                ent_target[tail] <= disp_target_in;
                ent_taken[tail]  <= disp_taken_in;
                ent_width[tail]  <= disp_width_in;
                tail             <= tail + 1'b1;
            end

            case ({disp_fire, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (do_flush) begin
                ent_valid <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
            end
        end
    end

`ifdef ROB_STATS_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stat_commit_out <= '0;
            stat_flush_out  <= '0;
        end else if (rdy_in) begin
            if (pop)      stat_commit_out <= stat_commit_out + 32'd1;
            if (do_flush) stat_flush_out  <= stat_flush_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_param.sv
module tb_rob_param;
    localparam int DEPTH  = 16;
    localparam int NUM_WB = 3;
    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int TAG_W  = 4;

    logic                    clk;
    logic                    rst_n;
    logic                    rdy;
    logic                    disp_en;
    logic [1:0]              disp_kind;
    logic [REG_W-1:0]        disp_rd;
    logic [XLEN-1:0]         disp_pc;
    logic [XLEN-1:0]         disp_target;
    logic                    disp_taken;
    logic [2:0]              disp_width;
    logic                    disp_rdy;
    logic [TAG_W-1:0]        disp_tag;
    logic [2*TAG_W-1:0]      lk_tag;
    logic [1:0]              lk_ready;
    logic [2*XLEN-1:0]       lk_value;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]  wb_value;
    logic [NUM_WB*XLEN-1:0]  wb_addr;
    logic [NUM_WB-1:0]       wb_is_addr;
    logic                    commit_en;
    logic [REG_W-1:0]        commit_rd;
    logic [XLEN-1:0]         commit_value;
    logic [TAG_W-1:0]        commit_tag;
    logic                    bp_en;
    logic                    bp_correct;
    logic [XLEN-1:0]         bp_pc;
    logic                    flush;
    logic [XLEN-1:0]         redirect_pc;
    logic                    mem_en;
    logic [XLEN-1:0]         mem_addr;
    logic [XLEN-1:0]         mem_data;
    logic [2:0]              mem_width;
    logic                    mem_done;
    logic                    dbg_state;
    logic [TAG_W-1:0]        dbg_head;
    logic [TAG_W:0]          dbg_count;

    rob_param #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .XLEN(XLEN), .REG_W(REG_W)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .disp_en_in(disp_en), .disp_kind_in(disp_kind), .disp_rd_in(disp_rd),
        .disp_pc_in(disp_pc), .disp_target_in(disp_target), .disp_taken_in(disp_taken),
        .disp_width_in(disp_width), .disp_rdy_out(disp_rdy), .disp_tag_out(disp_tag),
        .lk_tag_in(lk_tag), .lk_ready_out(lk_ready), .lk_value_out(lk_value),
        .wb_valid_in(wb_valid), .wb_tag_in(wb_tag), .wb_value_in(wb_value),
        .wb_addr_in(wb_addr), .wb_is_addr_in(wb_is_addr),
        .commit_en_out(commit_en), .commit_rd_out(commit_rd),
        .commit_value_out(commit_value), .commit_tag_out(commit_tag),
        .bp_en_out(bp_en), .bp_correct_out(bp_correct), .bp_pc_out(bp_pc),
        .flush_out(flush), .redirect_pc_out(redirect_pc),
        .mem_en_out(mem_en), .mem_addr_out(mem_addr), .mem_data_out(mem_data),
        .mem_width_out(mem_width), .mem_done_in(mem_done),
        .dbg_state_out(dbg_state), .dbg_head_out(dbg_head), .dbg_count_out(dbg_count)
    );

    // ------------------------------------------------------------ clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ scoreboard
    int tests = 0;
    int fails = 0;
    logic [40:0] exp_commit_q[$];   // {tag, rd, value}
    logic [32:0] exp_bp_q[$];       // {correct, pc}
    logic [31:0] exp_flush_q[$];    // redirect pc

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (commit_en) begin
                if (exp_commit_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL commit_unexpected: got tag %0d value 0x%0h expected none",
                             commit_tag, commit_value);
                end else begin
                    check("commit", {23'd0, commit_tag, commit_rd, commit_value},
                          {23'd0, exp_commit_q.pop_front()});
                end
            end
            if (bp_en) begin
                if (exp_bp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bp_unexpected: got pc 0x%0h expected none", bp_pc);
                end else begin
                    check("bp", {31'd0, bp_correct, bp_pc}, {31'd0, exp_bp_q.pop_front()});
                end
            end
            if (flush) begin
                if (exp_flush_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL flush_unexpected: got redirect 0x%0h expected none", redirect_pc);
                end else begin
                    check("flush_redirect", {32'd0, redirect_pc}, {32'd0, exp_flush_q.pop_front()});
                end
            end
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        disp_en = 0; disp_kind = 0; disp_rd = 0; disp_pc = 0; disp_target = 0;
        disp_taken = 0; disp_width = 0; lk_tag = 0; mem_done = 0;
        wb_valid = 0; wb_tag = 0; wb_value = 0; wb_addr = 0; wb_is_addr = 0;
    endtask

    task automatic dispatch(input logic [1:0] kind, input logic [REG_W-1:0] rd,
                            input logic [31:0] pc, input logic [31:0] target,
                            input logic taken, input logic [2:0] width);
        disp_en = 1; disp_kind = kind; disp_rd = rd; disp_pc = pc;
        disp_target = target; disp_taken = taken; disp_width = width;
        tick();
        disp_en = 0;
    endtask

    task automatic wb_set(input int ch, input logic [TAG_W-1:0] tag, input logic [31:0] value,
                          input logic [31:0] addr, input logic is_addr);
        wb_valid[ch] = 1'b1;
        wb_tag[ch*TAG_W +: TAG_W] = tag;
        wb_value[ch*XLEN +: XLEN] = value;
        wb_addr[ch*XLEN +: XLEN]  = addr;
        wb_is_addr[ch] = is_addr;
    endtask

    task automatic wb_clear();
        wb_valid = 0; wb_tag = 0; wb_value = 0; wb_addr = 0; wb_is_addr = 0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (dbg_count != 0 && n < 100) begin @(negedge clk); n++; end
        check(name, {59'd0, dbg_count}, 64'd0);
    endtask

    task automatic wait_flush(input string name);
        int n = 0;
        @(negedge clk);
        while (!flush && n < 20) begin @(negedge clk); n++; end
        check(name, {63'd0, flush}, 64'd1);
    endtask

    task automatic wait_mem(input string name);
        int n = 0;
        @(negedge clk);
        while (!mem_en && n < 20) begin @(negedge clk); n++; end
        check(name, {63'd0, mem_en}, 64'd1);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [31:0] v;
        logic [TAG_W-1:0] t;
        clear_inputs();
        rdy = 1; rst_n = 0;
        #12;
        check("rst_commit_en", {63'd0, commit_en}, 0);
        check("rst_flush", {63'd0, flush}, 0);
        check("rst_mem_en", {63'd0, mem_en}, 0);
        check("rst_tail", {60'd0, disp_tag}, 0);
        check("rst_count", {59'd0, dbg_count}, 0);
        check("rst_disp_rdy", {63'd0, disp_rdy}, 1);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Fill with 16 reg-writes. The expected retire values are fixed in advance.
        for (int i = 0; i < 16; i++) begin
            if (i < 2) v = 32'h10 + i;
            else if (i == 2) v = 32'h55;
            else if (i == 3) v = 32'h33;
            else v = 32'h100 + i;
            exp_commit_q.push_back({i[3:0], i[4:0], v});
        end
        for (int i = 0; i < 16; i++) dispatch(2'd0, i[4:0], i * 4, 0, 0, 3'b000);
        check("full_disp_rdy", {63'd0, disp_rdy}, 0);
        check("full_tail", {60'd0, disp_tag}, 0);
        check("full_count", {59'd0, dbg_count}, 16);
        dispatch(2'd0, 5'd31, 32'hDEAD, 0, 0, 3'b000);
        check("refused_tail", {60'd0, disp_tag}, 0);
        check("refused_count", {59'd0, dbg_count}, 16);

        // Same-cycle forward on rs, an unready entry on rt.
        wb_set(0, 4'd2, 32'h55, 0, 0);
        lk_tag = {4'd3, 4'd2};
        #1;
        check("fwd_ready", {62'd0, lk_ready}, 64'b01);
        check("fwd_value", {32'd0, lk_value[31:0]}, 32'h55);
        tick();
        wb_clear();
        lk_tag = {4'd2, 4'd5};
        #1;
        check("stored_ready", {62'd0, lk_ready}, 64'b10);
        check("stored_value", {32'd0, lk_value[63:32]}, 32'h55);

        // Channels 0 and 2 both target tag 3, so channel 2 must win.
        wb_set(0, 4'd3, 32'hAA, 0, 0);
        wb_set(1, 4'd0, 32'h10, 0, 0);
        wb_set(2, 4'd3, 32'h33, 0, 0);
        lk_tag = {4'd0, 4'd3};
        #1;
        check("fwd_prio_value", {32'd0, lk_value[31:0]}, 32'h33);
        tick();
        wb_clear();
        wb_set(0, 4'd1, 32'h11, 0, 0);
        tick();
        wb_clear();
        for (int i = 4; i < 16; i++) begin
            wb_set(0, i[3:0], 32'h100 + i, 0, 0);
            tick();
            wb_clear();
        end
        wait_empty("drain_count");
        lk_tag = {4'd0, 4'd0};
        #1;
        check("lk_invalid", {62'd0, lk_ready}, 0);

        // Branch predicted not-taken but taken: flush and redirect to the target.
        exp_bp_q.push_back({1'b0, 32'h100});
        exp_flush_q.push_back(32'h200);
        dispatch(2'd1, 0, 32'h100, 32'h200, 1'b0, 3'b000);
        dispatch(2'd0, 5'd7, 32'h104, 0, 0, 3'b000);
        wb_set(0, 4'd0, 32'h1, 0, 0);
        tick();
        wb_clear();
        wait_flush("br_flush_seen");
        check("br_flush_count", {59'd0, dbg_count}, 0);
        check("br_flush_tail", {60'd0, disp_tag}, 0);

        // Correctly predicted taken branch: no flush.
        exp_bp_q.push_back({1'b1, 32'h300});
        dispatch(2'd1, 0, 32'h300, 32'h400, 1'b1, 3'b000);
        wb_set(1, 4'd0, 32'h1, 0, 0);
        tick();
        wb_clear();
        wait_empty("br_ok_count");
        tick();
        check("br_ok_tail", {60'd0, disp_tag}, 1);

        // Branch predicted taken but not taken: redirect to pc+4.
        exp_bp_q.push_back({1'b0, 32'h500});
        exp_flush_q.push_back(32'h504);
        dispatch(2'd1, 0, 32'h500, 32'h900, 1'b1, 3'b000);
        wb_set(2, 4'd1, 32'h0, 0, 0);
        tick();
        wb_clear();
        wait_flush("br_nt_flush_seen");

        // jalr writes its link value and redirects to its target address.
        exp_commit_q.push_back({4'd0, 5'd1, 32'h604});
        exp_flush_q.push_back(32'h800);
        dispatch(2'd3, 5'd1, 32'h600, 0, 0, 3'b000);
        wb_set(0, 4'd0, 32'h604, 32'h800, 0);
        tick();
        wb_clear();
        wait_flush("jalr_flush_seen");

        // Store: mem_en stays high for three cycles, then mem_done pops the entry.
        dispatch(2'd2, 0, 32'h700, 0, 0, 3'b001);
        wb_set(0, 4'd0, 32'hAB, 0, 0);
        wb_set(1, 4'd0, 0, 32'h1000, 1);
        tick();
        wb_clear();
        wait_mem("st_mem_en");
        check("st_addr", {32'd0, mem_addr}, 32'h1000);
        check("st_data", {32'd0, mem_data}, 32'hAB);
        check("st_width", {61'd0, mem_width}, 3'b001);
        @(negedge clk);
        check("st_hold1", {63'd0, mem_en}, 1);
        check("st_hold_count", {59'd0, dbg_count}, 1);
        @(negedge clk);
        check("st_hold2", {63'd0, mem_en}, 1);
        mem_done = 1;
        tick();
        mem_done = 0;
        check("st_done_en", {63'd0, mem_en}, 0);
        check("st_done_count", {59'd0, dbg_count}, 0);

        // Wraparound: 40 alloc/writeback pairs starting from tail 1.
        for (int i = 0; i < 40; i++) begin
            t = disp_tag;
            exp_commit_q.push_back({t, i[4:0], 32'h2000 + i});
            dispatch(2'd0, i[4:0], 32'h3000 + i * 4, 0, 0, 3'b000);
            wb_set(i % NUM_WB, t, 32'h2000 + i, 0, 0);
            tick();
            wb_clear();
        end
        wait_empty("wrap_count");
        check("wrap_tail", {60'd0, disp_tag}, 9);

        // Asynchronous reset while a store is outstanding.
        dispatch(2'd2, 0, 32'h710, 0, 0, 3'b100);
        wb_set(0, 4'd9, 32'hCD, 0, 0);
        wb_set(1, 4'd9, 0, 32'h2000, 1);
        tick();
        wb_clear();
        wait_mem("rst_st_mem_en");
        #2;
        rst_n = 0;
        #1;
        check("rst_st_mem_en_low", {63'd0, mem_en}, 0);
        check("rst_st_head", {60'd0, dbg_head}, 0);
        check("rst_st_count", {59'd0, dbg_count}, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        tick();

        check("commit_q_empty", exp_commit_q.size(), 0);
        check("bp_q_empty", exp_bp_q.size(), 0);
        check("flush_q_empty", exp_flush_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
